// File: rtl/pixel_line_feeder.sv
// pixel_line_feeder: streams a stored 8-bit grayscale image into the
// line-buffered blur pipeline. The frame is sent as one zero padding line,
// a prefill burst of image lines, then one line per rising edge of i_intr,
// and finally one zero padding line after the last interrupt.
module pixel_line_feeder #(
  parameter int IMG_WIDTH     = 512,
  parameter int IMG_HEIGHT    = 512,
  parameter int PREFILL_LINES = 4,
  parameter int ADDR_W        = 18
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              i_start,
  input  logic              i_intr,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic              o_data_valid,
  output logic [7:0]        o_data,
  input  logic              i_data_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PAD_TOP   = 3'd1;
  localparam logic [2:0] S_PREFILL   = 3'd2;
  localparam logic [2:0] S_WAIT_INTR = 3'd3;
  localparam logic [2:0] S_LINE      = 3'd4;
  localparam logic [2:0] S_WAIT_PAD  = 3'd5;
  localparam logic [2:0] S_PAD_BOT   = 3'd6;
  localparam logic [2:0] S_DRAIN     = 3'd7;

  localparam int COL_W  = $clog2(IMG_WIDTH + 1);
  localparam int LINE_W = $clog2(IMG_HEIGHT + 1);
  // Prefill never sends more lines than the image holds.
  localparam int PF_END = (PREFILL_LINES < IMG_HEIGHT) ? PREFILL_LINES : IMG_HEIGHT;

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] HEIGHT_L = LINE_W'(IMG_HEIGHT);
  localparam logic [LINE_W-1:0] PF_END_L = LINE_W'(PF_END);

  logic [2:0]        state;
  logic [COL_W-1:0]  col_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic [LINE_W-1:0] line_next;
  logic [ADDR_W-1:0] addr_cnt;
  logic              ret_q;
  logic              zero_q;
  logic              intr_q;
  logic              intr_pending;
  logic              intr_edge;
  logic              in_wait;
  logic              consume;
  logic [2:0]        occ;
  logic              can_issue;
  logic              rd_issue;
  logic              zero_issue;
  logic              last_col;
  logic              pipe_empty;
  logic              push;
  logic [7:0]        push_data;
  logic              pop;
  logic [7:0]        fifo_mem [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        fifo_count;

  // Occupancy counts FIFO entries plus items that land on the next edge;
  // a read whose address phase is still pending is the fourth slot of slack.
  assign occ        = fifo_count + {2'b00, ret_q} + {2'b00, zero_q};
  assign can_issue  = (occ <= 3'd2);
  assign rd_issue   = can_issue && ((state == S_PREFILL) || (state == S_LINE));
  assign zero_issue = can_issue && ((state == S_PAD_TOP) || (state == S_PAD_BOT));
  assign last_col   = (col_cnt == LAST_COL);
  assign line_next  = line_cnt + LINE_W'(1);
  assign pipe_empty = (fifo_count == 3'd0) && !o_mem_rd_en && !ret_q && !zero_q;

  assign intr_edge  = i_intr && !intr_q;
  assign in_wait    = (state == S_WAIT_INTR) || (state == S_WAIT_PAD);
  assign consume    = in_wait && intr_pending;

  assign push       = ret_q || zero_q;
  assign push_data  = ret_q ? i_mem_data : 8'h00;
  assign pop        = o_data_valid && i_data_ready;

  assign o_data_valid = (fifo_count != 3'd0);
  assign o_data       = o_data_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign o_busy       = (state != S_IDLE);

  // Frame sequencer: walks padding, prefill and interrupt-paced lines.
  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      state    <= S_IDLE;
      col_cnt  <= '0;
      line_cnt <= '0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          col_cnt  <= '0;
          line_cnt <= '0;
          if (i_start) state <= S_PAD_TOP;
        end
        S_PAD_TOP: if (zero_issue && last_col) state <= S_PREFILL;
        S_PREFILL: begin
          if (rd_issue && last_col) begin
            line_cnt <= line_next;
            if (line_next == PF_END_L)
              state <= (line_next == HEIGHT_L) ? S_WAIT_PAD : S_WAIT_INTR;
          end
        end
        S_WAIT_INTR: if (intr_pending) state <= S_LINE;
        S_LINE: begin
          if (rd_issue && last_col) begin
            line_cnt <= line_next;
            state    <= (line_next == HEIGHT_L) ? S_WAIT_PAD : S_WAIT_INTR;
          end
        end
        S_WAIT_PAD: if (intr_pending) state <= S_PAD_BOT;
        S_PAD_BOT: if (zero_issue && last_col) state <= S_DRAIN;
        S_DRAIN: begin
          if (pipe_empty) begin
            o_done <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (rd_issue || zero_issue)
        col_cnt <= last_col ? '0 : col_cnt + COL_W'(1);
    end
  end

  // Memory request pipeline: registered strobe/address, then a return stage
  // that lines up with the cycle the synchronous memory presents its data.
  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      o_mem_rd_en <= 1'b0;
      o_mem_addr  <= '0;
      addr_cnt    <= '0;
      ret_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      o_mem_rd_en <= rd_issue;
      ret_q       <= o_mem_rd_en;
      zero_q      <= zero_issue;
      if (state == S_IDLE) begin
        addr_cnt <= '0;
      end else if (rd_issue) begin
        o_mem_addr <= addr_cnt;
        addr_cnt   <= addr_cnt + ADDR_W'(1);
      end
    end
  end

  // Interrupt edge capture into a sticky flag consumed by the wait states.
  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      intr_q       <= 1'b0;
      intr_pending <= 1'b0;
    end else begin
      intr_q <= i_intr;
      if (state == S_IDLE)
        intr_pending <= 1'b0;
      else if (intr_edge && (state != S_DRAIN))
        intr_pending <= 1'b1;
      else if (consume)
        intr_pending <= 1'b0;
    end
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + {2'b00, push} - {2'b00, pop};
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head.
  always_ff @(posedge axi_clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

endmodule
